// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: state encoding,
// instruction size, PC alignment and counter widths.
package fetch_pkg;

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int INSTR_BYTES   = 4;
  localparam int PC_ALIGN_BITS = $clog2(INSTR_BYTES);
  localparam logic [31:0] PC_ALIGN_MASK = ~(32'(INSTR_BYTES) - 32'd1);

  // Wide enough for any TIMEOUT_CYC up to 255.
  localparam int TMO_CNT_W = 8;

  localparam int PERF_W = 32;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Two free-running event counters (handoffs, blocked HOLD cycles) for the
// fetch controller; only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_ctr
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetched_inc,
  input  logic              stall_inc,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_stall
);

  logic [1:0]             inc;
  logic [1:0][PERF_W-1:0] cnt_out;

  assign inc = {stall_inc, fetched_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [PERF_W-1:0] cnt_reg;

      // Wraps naturally at 2^PERF_W.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (inc[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_out[gi] = cnt_reg;
    end
  endgenerate

  assign perf_fetched = cnt_out[0];
  assign perf_stall   = cnt_out[1];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer between PC register, imem port and decode. Optional
// performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_write,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

  logic [2:0]           state_reg, state_next;
  logic                 kill_reg, kill_next;
  logic [TMO_CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [DATA_W-1:0]    id_instr_reg;
  logic [ADDR_W-1:0]    id_pc_reg;

  logic                 pc_write_c;
  logic [ADDR_W-1:0]    next_pc_c;
  logic                 imem_req_c;
  logic                 load_id_pc;
  logic                 load_instr;
  logic [ADDR_W-1:0]    redirect_tgt;
  logic [ADDR_W-1:0]    pc_inc;

  assign redirect_tgt = {redirect_pc[ADDR_W-1:PC_ALIGN_BITS], PC_ALIGN_BITS'(0)};
  assign pc_inc       = pc_cur + ADDR_W'(INSTR_BYTES);

  always_comb begin
    state_next   = state_reg;
    kill_next    = kill_reg;
    tmo_cnt_next = tmo_cnt_reg;
    pc_write_c   = 1'b0;
    next_pc_c    = '0;
    imem_req_c   = 1'b0;
    load_id_pc   = 1'b0;
    load_instr   = 1'b0;

    case (state_reg)
      ST_BOOT: begin
        pc_write_c = 1'b1;
        next_pc_c  = RESET_PC;
        state_next = ST_REQ;
      end

      ST_REQ: begin
        if (redirect) begin
          // Request withheld so imem never sees the stale PC.
          pc_write_c = 1'b1;
          next_pc_c  = redirect_tgt;
        end else begin
          imem_req_c = 1'b1;
          if (imem_ready) begin
            load_id_pc   = 1'b1;
            kill_next    = 1'b0;
            tmo_cnt_next = '0;
            state_next   = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          kill_next = 1'b0;
          if (redirect) begin
            pc_write_c = 1'b1;
            next_pc_c  = redirect_tgt;
            state_next = ST_REQ;
          end else if (kill_reg) begin
            state_next = ST_REQ;
          end else begin
            load_instr = 1'b1;
            pc_write_c = 1'b1;
            next_pc_c  = pc_inc;
            state_next = ST_HOLD;
          end
        end else begin
          // The outstanding response must still be drained, so only mark it dead.
          if (redirect) begin
            pc_write_c = 1'b1;
            next_pc_c  = redirect_tgt;
            kill_next  = 1'b1;
          end
          if (tmo_cnt_reg == TMO_LAST) begin
            state_next = ST_FAULT;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_write_c = 1'b1;
          next_pc_c  = redirect_tgt;
          state_next = ST_REQ;
        end else if (id_ready && !stall) begin
          state_next = ST_REQ;
        end
      end

      ST_FAULT: begin
        state_next = ST_FAULT;
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_BOOT;
      kill_reg     <= 1'b0;
      tmo_cnt_reg  <= '0;
      id_instr_reg <= '0;
      id_pc_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      kill_reg    <= kill_next;
      tmo_cnt_reg <= tmo_cnt_next;
      if (load_instr) begin
        id_instr_reg <= imem_rdata;
      end
      if (load_id_pc) begin
        id_pc_reg <= pc_cur;
      end
    end
  end

  // BOOT is the reset state, so its PC load is gated until reset is released.
  assign pc_write    = pc_write_c & reset;
  assign next_pc     = reset ? next_pc_c : '0;
  assign imem_req    = imem_req_c;
  assign imem_addr   = imem_req_c ? pc_cur : '0;
  assign id_valid    = (state_reg == ST_HOLD);
  assign id_instr    = id_instr_reg;
  assign id_pc       = id_pc_reg;
  assign fetch_fault = (state_reg == ST_FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic handoff;
  logic blocked;

  assign handoff = (state_reg == ST_HOLD) && !redirect && id_ready && !stall;
  assign blocked = (state_reg == ST_HOLD) && !redirect && !(id_ready && !stall);

  fetch_perf_ctr u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetched_inc  (handoff),
    .stall_inc    (blocked),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed, table-driven bench for instr_fetch_ctrl; perf counters are
// exercised only when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_cur;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  instr_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .next_pc     (next_pc),
    .pc_write    (pc_write),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        chk;
    logic        rst;
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        idr;
    logic        stl;
    logic        rd;
    logic [31:0] rpc;
    logic        e_pw;
    logic [31:0] e_npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_instr;
    logic [31:0] e_idpc;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string nm, input logic rst, input logic [31:0] pc,
    input logic rdy, input logic rv, input logic [31:0] rdata,
    input logic idr, input logic stl, input logic rd, input logic [31:0] rpc,
    input logic pw, input logic [31:0] npc, input logic req, input logic [31:0] addr,
    input logic idv, input logic [31:0] instr, input logic [31:0] idpc, input logic flt);
    vec_t v;
    v.nm = nm; v.chk = 1'b1; v.rst = rst; v.pc = pc; v.rdy = rdy; v.rv = rv;
    v.rdata = rdata; v.idr = idr; v.stl = stl; v.rd = rd; v.rpc = rpc;
    v.e_pw = pw; v.e_npc = npc; v.e_req = req; v.e_addr = addr; v.e_idv = idv;
    v.e_instr = instr; v.e_idpc = idpc; v.e_flt = flt;
    return v;
  endfunction

  function automatic vec_t mkin(
    input string nm, input logic [31:0] pc, input logic rdy, input logic rv,
    input logic idr, input logic stl);
    vec_t v;
    v = mk(nm, 1'b1, pc, rdy, rv, 32'h0BAD_0000, idr, stl, 1'b0, 32'h0,
           1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    v.chk = 1'b0;
    return v;
  endfunction

  task automatic chk(input string vn, input string f, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", vn, f, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    reset       = v.rst;
    pc_cur      = v.pc;
    imem_ready  = v.rdy;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    id_ready    = v.idr;
    stall       = v.stl;
    redirect    = v.rd;
    redirect_pc = v.rpc;
    #1;
    if (v.chk) begin
      chk(v.nm, "pc_write",    {31'b0, pc_write},    {31'b0, v.e_pw});
      chk(v.nm, "next_pc",     next_pc,              v.e_npc);
      chk(v.nm, "imem_req",    {31'b0, imem_req},    {31'b0, v.e_req});
      chk(v.nm, "imem_addr",   imem_addr,            v.e_addr);
      chk(v.nm, "id_valid",    {31'b0, id_valid},    {31'b0, v.e_idv});
      chk(v.nm, "id_instr",    id_instr,             v.e_instr);
      chk(v.nm, "id_pc",       id_pc,                v.e_idpc);
      chk(v.nm, "fetch_fault", {31'b0, fetch_fault}, {31'b0, v.e_flt});
    end
    $display("cyc %-12s pc=%h pw=%0d npc=%h req=%0d addr=%h idv=%0d instr=%h idpc=%h flt=%0d",
             v.nm, v.pc, pc_write, next_pc, imem_req, imem_addr, id_valid, id_instr, id_pc, fetch_fault);
  endtask

  localparam logic [31:0] I0 = 32'h2002_0005;
  localparam logic [31:0] I1 = 32'h0000_0013;
  localparam logic [31:0] I2 = 32'h2222_0001;
  localparam logic [31:0] I3 = 32'hABCD_0001;
  localparam logic [31:0] TOP = 32'hFFFF_FFFC;

  initial begin
    reset = 1'b0; pc_cur = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //          name          rst pc     rdy rv rdata        idr stl rd rpc            pw npc     req addr   idv instr idpc flt
    vecs.push_back(mk("reset",     0, 32'h0,   0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("boot",      1, 32'h0,   0, 0, 32'h0,        0, 0, 1, 32'h80,       1, 32'h0,  0, 32'h0,  0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("req0",      1, 32'h0,   1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("rsp0",      1, 32'h0,   0, 1, I0,           0, 0, 0, 32'h0,        1, 32'h4,  0, 32'h0,  0, 32'h0, 32'h0, 0));
    vecs.push_back(mk("stall1",    1, 32'h4,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("stall2",    1, 32'h4,   0, 1, 32'h5555,     1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("stall3",    1, 32'h4,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("stall4",    1, 32'h4,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("stall5",    1, 32'h4,   0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("handoff0",  1, 32'h4,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I0,    32'h0, 0));
    vecs.push_back(mk("req4_nrdy", 1, 32'h4,   0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h4,  0, I0,    32'h0, 0));
    vecs.push_back(mk("req4",      1, 32'h4,   1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h4,  0, I0,    32'h0, 0));
    vecs.push_back(mk("redir_wait",1, 32'h4,   0, 0, 32'h0,        0, 0, 1, 32'h43,       1, 32'h40, 0, 32'h0,  0, I0,    32'h4, 0));
    vecs.push_back(mk("kill_drop", 1, 32'h40,  0, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  0, I0,    32'h4, 0));
    vecs.push_back(mk("req40",     1, 32'h40,  1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h40, 0, I0,    32'h4, 0));
    vecs.push_back(mk("rsp40",     1, 32'h40,  0, 1, I1,           0, 0, 0, 32'h0,        1, 32'h44, 0, 32'h0,  0, I0,    32'h40, 0));
    vecs.push_back(mk("redir_hold",1, 32'h44,  0, 0, 32'h0,        1, 0, 1, 32'h100,      1, 32'h100,0, 32'h0,  1, I1,    32'h40, 0));
    vecs.push_back(mk("redir_req1",1, 32'h100, 1, 0, 32'h0,        0, 0, 1, 32'h202,      1, 32'h200,0, 32'h0,  0, I1,    32'h40, 0));
    vecs.push_back(mk("redir_req2",1, 32'h200, 1, 0, 32'h0,        0, 0, 1, 32'h300,      1, 32'h300,0, 32'h0,  0, I1,    32'h40, 0));
    vecs.push_back(mk("req300",    1, 32'h300, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h300,0, I1,    32'h40, 0));
    vecs.push_back(mk("redir_rsp", 1, 32'h300, 0, 1, 32'h1111,     0, 0, 1, 32'h80,       1, 32'h80, 0, 32'h0,  0, I1,    32'h300, 0));
    vecs.push_back(mk("req80",     1, 32'h80,  1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h80, 0, I1,    32'h300, 0));
    vecs.push_back(mk("rsp80",     1, 32'h80,  0, 1, I2,           0, 0, 0, 32'h0,        1, 32'h84, 0, 32'h0,  0, I1,    32'h80, 0));
    vecs.push_back(mk("hold_nrdy", 1, 32'h84,  0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I2,    32'h80, 0));
    vecs.push_back(mk("handoff80", 1, 32'h84,  0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I2,    32'h80, 0));
    vecs.push_back(mk("redir_top", 1, 32'h84,  0, 0, 32'h0,        0, 0, 1, 32'hFFFFFFFF, 1, TOP,    0, 32'h0,  0, I2,    32'h80, 0));
    vecs.push_back(mk("req_top",   1, TOP,     1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, TOP,    0, I2,    32'h80, 0));
    vecs.push_back(mk("rsp_top",   1, TOP,     0, 1, I3,           0, 0, 0, 32'h0,        1, 32'h0,  0, 32'h0,  0, I2,    TOP,   0));
    vecs.push_back(mk("hand_top",  1, 32'h0,   0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,  0, 32'h0,  1, I3,    TOP,   0));
    vecs.push_back(mk("stale_req", 1, 32'h0,   0, 1, 32'h5555,     0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0, I3,    TOP,   0));
    vecs.push_back(mk("req_tmo",   1, 32'h0,   1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,  1, 32'h0,  0, I3,    TOP,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Sixteen silent WAIT cycles: fault appears only after the last one.
    for (int i = 0; i < 16; i++) begin
      step(mk("wait_tmo", 1, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0,
              0, 32'h0, 0, 32'h0, 0, I3, 32'h0, 0));
    end
    for (int i = 0; i < 3; i++) begin
      step(mk("fault", 1, 32'h0, 1, 1, 32'h9999, 1, 0, 1, 32'h40,
              0, 32'h0, 0, 32'h0, 0, I3, 32'h0, 1));
    end

    step(mk("reset2",  0, 32'h0, 0, 1, 32'h7777, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
    step(mk("boot2",   1, 32'h0, 0, 1, 32'h7777, 0, 0, 0, 32'h0,
            1, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
    step(mk("stale2",  1, 32'h0, 0, 1, 32'h7777, 0, 0, 0, 32'h0,
            0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0, 0));

`ifdef FETCH_PERF_CNT_EN
    // Three handoffs with four blocked HOLD cycles in between.
    step(mkin("p_req1",  32'h0, 1, 0, 0, 0));
    step(mkin("p_rsp1",  32'h0, 0, 1, 0, 0));
    step(mkin("p_blk1",  32'h4, 0, 0, 0, 0));
    step(mkin("p_blk2",  32'h4, 0, 0, 0, 0));
    step(mkin("p_hand1", 32'h4, 0, 0, 1, 0));
    step(mkin("p_req2",  32'h4, 1, 0, 0, 0));
    step(mkin("p_rsp2",  32'h4, 0, 1, 0, 0));
    step(mkin("p_blk3",  32'h8, 0, 0, 1, 1));
    step(mkin("p_blk4",  32'h8, 0, 0, 1, 1));
    step(mkin("p_hand2", 32'h8, 0, 0, 1, 0));
    step(mkin("p_req3",  32'h8, 1, 0, 0, 0));
    step(mkin("p_rsp3",  32'h8, 0, 1, 0, 0));
    step(mkin("p_hand3", 32'hC, 0, 0, 1, 0));
    step(mkin("p_idle",  32'hC, 0, 0, 0, 0));
    chk("perf", "perf_fetched", perf_fetched, 32'd3);
    chk("perf", "perf_stall",   perf_stall,   32'd4);
    $display("cyc perf         fetched=%0d stall=%0d", perf_fetched, perf_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
